apb_mem_bridge: RTL and testbench

//   APB4 completer that fronts the 1024x32 single-port RAM and drives its

---
 rtl/apb_mem_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_mem_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_bridge
// Description : APB4 completer in front of a 1024x32 single-port RAM with
//               asynchronous read. Each APB transfer becomes one RAM access.
//               WAIT_STATES adds that many ACCESS cycles with pready low.
//               Byte strobes are applied as a single-cycle read-modify-write:
//               the merged word is driven during the response cycle and
//               committed by the RAM on the edge that ends it. Misaligned or
//               out-of-range addresses complete with pslverr=1 and do not
//               touch the RAM.
// Ports       : clk, rst (sync, active-high)
//               psel, penable, pwrite, paddr, pwdata, pstrb   APB request
//               pready, prdata, pslverr                       APB response
//               mem_addr, mem_we, mem_wdata, mem_rdata         RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_bridge #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [9:0]        mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_wait_init = WAIT_STATES[3:0];

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [9:0]  r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic        r_err;
    logic        r_pready;
    logic        r_pslverr;
    logic        r_we;

    logic        w_setup;
    logic        w_cap;
    logic        w_hi_err;
    logic        w_err_in;
    logic        w_err_sel;
    logic        w_write_sel;
    logic [3:0]  w_strb_sel;
    logic        w_enter_resp;

    // Address bits above the 4 KiB window must be zero.
    generate
        if (ADDR_W > 12) begin : g_hi_addr
            assign w_hi_err = |paddr[ADDR_W-1:12];
        end else begin : g_no_hi_addr
            assign w_hi_err = 1'b0;
        end
    endgenerate

    assign w_setup  = psel & ~penable;
    assign w_cap    = (r_state == S_IDLE) & w_setup;
    assign w_err_in = (paddr[1:0] != 2'b00) | w_hi_err;

    // With zero wait states the response starts on the edge that captures
    // the transfer, so the response flags must look at the incoming request
    // rather than the (not yet loaded) holding registers.
    assign w_err_sel   = w_cap ? w_err_in : r_err;
    assign w_write_sel = w_cap ? pwrite   : r_write;
    assign w_strb_sel  = w_cap ? pstrb    : r_strb;
    assign w_enter_resp = (w_next == S_RESP);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_next = (c_wait_init != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, transfer capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 10'd0;
            r_write   <= 1'b0;
            r_wdata   <= 32'd0;
            r_strb    <= 4'd0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_we      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_addr  <= paddr[11:2];
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_err   <= w_err_in;
                r_cnt   <= c_wait_init;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_pready  <= w_enter_resp;
            r_pslverr <= w_enter_resp & w_err_sel;
            r_we      <= w_enter_resp & w_write_sel & ~w_err_sel & (|w_strb_sel);
        end
    end

    assign pready   = r_pready;
    assign pslverr  = r_pslverr;
    assign mem_addr = r_addr;
    // A reset arriving during the response cycle must keep the RAM from
    // committing at that same edge, hence the direct gating by rst.
    assign mem_we   = r_we & ~rst;
    assign prdata   = (r_pready & ~r_write & ~r_err) ? mem_rdata : 32'd0;

    // Byte-lane merge of the captured write data over the current RAM word.
    always_comb begin
        mem_wdata = 32'd0;
        if (r_pready) begin
            for (int i = 0; i < 4; i++) begin
                mem_wdata[8*i +: 8] = r_strb[i] ? r_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_mem_bridge
// Description : Self-checking bench for apb_mem_bridge. Two instances
//               (0 and 3 wait states) each drive their own RAM model. A
//               word-level reference memory per instance predicts read data,
//               error responses and RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_clr;
    logic [1:0]  psel, penable, pwrite;
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic        mem_we  [2];
    logic [31:0] prdata    [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [9:0]  mem_addr  [2];

    logic [31:0] ram0 [1024];
    logic [31:0] ram1 [1024];
    logic [31:0] gold [2][1024];

    int vecs = 0;
    int miscmp = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_bridge #(.ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    apb_mem_bridge #(.ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    // Async-read RAM models
    assign mem_rdata[0] = ram0[mem_addr[0]];
    assign mem_rdata[1] = ram1[mem_addr[1]];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram0[i] <= 32'd0;
        end else if (mem_we[0]) begin
            ram0[mem_addr[0]] <= mem_wdata[0];
        end
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram1[i] <= 32'd0;
        end else if (mem_we[1]) begin
            ram1[mem_addr[1]] <= mem_wdata[1];
        end
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] ram_rd(input int g, input int i);
        return (g == 0) ? ram0[i] : ram1[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: word memory, byte-lane writes, error on misaligned
    // or >= 4 KiB addresses. Returns the expected read data and error flag.
    function automatic void model(input int g, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  output logic [31:0] er, output bit ee);
        int w;
        w  = int'(addr[11:2]);
        ee = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
        er = 32'd0;
        if (!ee) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) gold[g][w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                er = gold[g][w];
            end
        end
    endfunction

    // One APB transfer. Returns at the falling edge of the response cycle
    // with psel/penable still asserted so another transfer may follow.
    task automatic apb(input int g, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output bit err, output int rc);
        int k;
        bit seen;
        bit quiet;
        bit exp_err;
        bit exp_we;
        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'h1000);
        exp_we  = wr && !exp_err && (strb != 4'd0);
        @(posedge clk); #1;
        psel[g] = 1'b1; penable[g] = 1'b0; pwrite[g] = wr;
        paddr[g] = addr; pwdata[g] = wdata; pstrb[g] = strb;
        @(negedge clk);
        chk("setup_pready", {31'd0, pready[g]}, 32'd0);
        @(posedge clk); #1;
        penable[g] = 1'b1;
        k = 1; seen = 0; quiet = 1;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (pready[g]) begin
                seen = 1;
            end else begin
                if (pslverr[g] || mem_we[g] || prdata[g] != 32'd0) quiet = 0;
                k++;
                @(posedge clk); #1;
            end
        end
        rc = cyc;
        chk("pready_seen", {31'd0, seen}, 32'd1);
        chk("latency", k, 1 + ws_of(g));
        chk("quiet_while_waiting", {31'd0, quiet}, 32'd1);
        chk("resp_mem_we", {31'd0, mem_we[g]}, {31'd0, exp_we});
        chk("resp_mem_addr", {22'd0, mem_addr[g]}, {22'd0, addr[11:2]});
        rdata = prdata[g];
        err   = pslverr[g];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = 2'b00; penable = 2'b00;
        @(negedge clk);
        chk("pready_one_cycle0", {31'd0, pready[0]}, 32'd0);
        chk("pready_one_cycle1", {31'd0, pready[1]}, 32'd0);
    endtask

    // Model-checked transfer
    task automatic xfer(input int g, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, output int rc);
        logic [31:0] er, ar;
        bit ee, ae;
        model(g, wr, addr, wdata, strb, er, ee);
        apb(g, wr, addr, wdata, strb, ar, ae, rc);
        chk("model_prdata", ar, er);
        chk("model_pslverr", {31'd0, ae}, {31'd0, ee});
    endtask

    typedef struct {
        int          g;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] er, ar;
        bit ee, ae, bad;
        int rc, rc0, rc1, rc2;

        tbl[0]  = '{0, 1'b1, 32'h010,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{0, 1'b0, 32'h010,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h010,  32'h11223344, 4'h5, 32'h0,        1'b0};
        tbl[3]  = '{0, 1'b0, 32'h010,  32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{1, 1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[5]  = '{1, 1'b0, 32'hFFC,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        tbl[6]  = '{0, 1'b1, 32'h002,  32'h12345678, 4'hF, 32'h0,        1'b1};
        tbl[7]  = '{0, 1'b1, 32'h1000, 32'h87654321, 4'hF, 32'h0,        1'b1};
        tbl[8]  = '{0, 1'b0, 32'h010,  32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        tbl[9]  = '{0, 1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[10] = '{0, 1'b1, 32'h014,  32'hAAAAAAAA, 4'h0, 32'h0,        1'b0};
        tbl[11] = '{0, 1'b0, 32'h014,  32'h0,        4'hF, 32'h0,        1'b0};
        tbl[12] = '{1, 1'b0, 32'h1003, 32'h0,        4'hF, 32'h0,        1'b1};

        psel = 2'b00; penable = 2'b00; pwrite = 2'b00;
        for (int g = 0; g < 2; g++) begin
            paddr[g] = 32'd0; pwdata[g] = 32'd0; pstrb[g] = 4'd0;
            for (int i = 0; i < 1024; i++) gold[g][i] = 32'd0;
        end
        rst = 1'b1; ram_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; ram_clr = 1'b0;

        // Reset state
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_pready",    {31'd0, pready[g]},  32'd0);
            chk("rst_pslverr",   {31'd0, pslverr[g]}, 32'd0);
            chk("rst_mem_we",    {31'd0, mem_we[g]},  32'd0);
            chk("rst_mem_addr",  {22'd0, mem_addr[g]}, 32'd0);
            chk("rst_prdata",    prdata[g],    32'd0);
            chk("rst_mem_wdata", mem_wdata[g], 32'd0);
        end

        // Directed table
        for (int i = 0; i < 13; i++) begin
            model(tbl[i].g, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, er, ee);
            apb(tbl[i].g, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, ar, ae, rc);
            idle();
            chk($sformatf("tbl%0d_prdata", i), ar, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_pslverr", i), {31'd0, ae}, {31'd0, tbl[i].exp_err});
        end
        chk("ram0_word4", ram0[4], 32'hDE22BE44);
        chk("ram0_word0_untouched", ram0[0], 32'd0);
        chk("ram1_word1023", ram1[1023], 32'hCAFEF00D);

        // Back-to-back writes, no idle cycles between transfers
        xfer(0, 1'b1, 32'h000, 32'hA0A0A0A0, 4'hF, rc0);
        xfer(0, 1'b1, 32'h004, 32'hB1B1B1B1, 4'hF, rc1);
        xfer(0, 1'b1, 32'h008, 32'hC2C2C2C2, 4'hF, rc2);
        idle();
        chk("b2b_gap1", rc1 - rc0, 2);
        chk("b2b_gap2", rc2 - rc1, 2);
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b0, 32'(4 * i), 32'd0, 4'hF, rc);
            idle();
        end

        // Reset during the response cycle of a write
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h020; pwdata[0] = 32'h5555AAAA; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_resp_mem_we", {31'd0, mem_we[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 2'b00; penable = 2'b00;
        @(negedge clk);
        chk("post_rst_pready", {31'd0, pready[0]}, 32'd0);
        chk("post_rst_mem_we", {31'd0, mem_we[0]}, 32'd0);
        chk("post_rst_ram_unchanged", ram0[8], gold[0][8]);
        xfer(0, 1'b1, 32'h020, 32'h13579BDF, 4'hF, rc);
        idle();
        xfer(0, 1'b0, 32'h020, 32'd0, 4'hF, rc);
        idle();

        // Abort during wait states: psel drops, no response, no write
        @(posedge clk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h030; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready[1] || mem_we[1]) bad = 1;
        end
        chk("abort_no_response", {31'd0, bad}, 32'd0);
        chk("abort_ram_unchanged", ram1[12], gold[1][12]);
        xfer(1, 1'b0, 32'h030, 32'd0, 4'hF, rc);
        idle();

        // penable without a preceding SETUP is ignored
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h040; pwdata[0] = 32'h0BADF00D; pstrb[0] = 4'hF;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (pready[0] || mem_we[0]) bad = 1;
        end
        chk("no_setup_ignored", {31'd0, bad}, 32'd0);
        idle();

        // Randomized transfers checked against the reference model
        begin
            int prev_g;
            prev_g = 0;
            for (int n = 0; n < 80; n++) begin
                int g, sel;
                bit wr;
                logic [31:0] addr;
                logic [3:0] strb;
                g   = int'($urandom_range(0, 1));
                wr  = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else if (sel == 1) addr = 32'h1000 + 32'($urandom_range(0, 15) * 4);
                else if (sel == 2) addr = 32'hFFC;
                else               addr = 32'($urandom_range(0, 15) * 4);
                strb = 4'($urandom_range(0, 15));
                if (g != prev_g) idle();
                xfer(g, wr, addr, $urandom, strb, rc);
                if ($urandom_range(0, 1) == 1) idle();
                prev_g = g;
            end
            idle();
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_ram0_%0d", i), ram0[i], gold[0][i]);
            chk($sformatf("final_ram1_%0d", i), ram1[i], gold[1][i]);
        end
        chk("final_ram0_1023", ram_rd(0, 1023), gold[0][1023]);
        chk("final_ram1_1023", ram_rd(1, 1023), gold[1][1023]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
`default_nettype wire
